// File: rtl/alu_pkg.sv
// Shared encodings for the CSE141L ALU and its sequencer.
// Instruction layout is {op[2:0], func[2:0], r[2:0]}. The ALU sees the upper six bits.
package alu_pkg;

    // Major opcodes. Ops 000 and 001 are unassigned and execute as NOP.
    localparam logic [2:0] OP_ADD       = 3'b010;
    localparam logic [2:0] OP_MATCH     = 3'b011;
    localparam logic [2:0] OP_LT        = 3'b100;
    localparam logic [2:0] OP_DIST      = 3'b101;
    localparam logic [2:0] OP_HAS_FUNCA = 3'b110;
    localparam logic [2:0] OP_HAS_FUNCB = 3'b111;

    // A-type functions. Func 110 is unassigned. Func 111 is HALT.
    localparam logic [2:0] FA_LSL  = 3'b000;
    localparam logic [2:0] FA_LSR  = 3'b001;
    localparam logic [2:0] FA_INCR = 3'b010;
    localparam logic [2:0] FA_ZERO = 3'b011;
    localparam logic [2:0] FA_AND1 = 3'b100;
    localparam logic [2:0] FA_EQZ  = 3'b101;
    localparam logic [2:0] FA_HALT = 3'b111;

    // B-type functions. Funcs 010 through 111 are unassigned.
    localparam logic [2:0] FB_BNO = 3'b000;
    localparam logic [2:0] FB_BOF = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } seq_state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] func;
        logic [2:0] r;
    } instr_t;

    // Per-instruction control bits produced by op_decode.
    typedef struct packed {
        logic wr_en;
        logic flag_en;
        logic is_branch;
        logic br_on;
        logic is_halt;
    } op_ctrl_t;

    function automatic logic [5:0] opcode_of(input instr_t i);
        return {i.op, i.func};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus bundle between alu_sequencer and its ROM, register file, ALU and branch LUT.
// Optional macro SEQ_CYCLE_COUNT_EN adds the cycle_count signal.
// The master modport is the sequencer side. The slave modport is the environment side.
interface alu_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [PC_W-1:0]    start_pc;
    logic               busy;
    logic               done;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [5:0]         alu_opcode;
    logic               alu_overflow;
    logic [2:0]         rf_raddr;
    logic [2:0]         rf_waddr;
    logic               rf_we;
    logic [2:0]         br_idx;
    logic [PC_W-1:0]    br_target;
    logic               flag;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0]        cycle_count;

    modport master (
        input  start, start_pc, imem_data, alu_overflow, br_target,
        output busy, done, imem_addr, alu_opcode, rf_raddr, rf_waddr,
               rf_we, br_idx, flag, cycle_count
    );

    modport slave (
        output start, start_pc, imem_data, alu_overflow, br_target,
        input  busy, done, imem_addr, alu_opcode, rf_raddr, rf_waddr,
               rf_we, br_idx, flag, cycle_count
    );
`else
    modport master (
        input  start, start_pc, imem_data, alu_overflow, br_target,
        output busy, done, imem_addr, alu_opcode, rf_raddr, rf_waddr,
               rf_we, br_idx, flag
    );

    modport slave (
        output start, start_pc, imem_data, alu_overflow, br_target,
        input  busy, done, imem_addr, alu_opcode, rf_raddr, rf_waddr,
               rf_we, br_idx, flag
    );
`endif

endinterface

// File: rtl/op_decode.sv
// Combinational instruction classifier for the sequencer.
// Any encoding not listed here yields all-zero control, which makes it a NOP.
module op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    output op_ctrl_t   ctrl
);

    logic [2:0] op;
    logic [2:0] func;

    assign op   = opcode[5:3];
    assign func = opcode[2:0];

    // Map opcode/func to write-back, flag, branch and halt controls.
    always_comb begin
        ctrl = '0;
        case (op)
            OP_ADD: begin
                ctrl.wr_en   = 1'b1;
                ctrl.flag_en = 1'b1;
            end
            OP_MATCH: ctrl.flag_en = 1'b1;
            OP_LT:    ctrl.flag_en = 1'b1;
            OP_DIST:  ctrl.wr_en   = 1'b1;
            OP_HAS_FUNCA: begin
                case (func)
                    FA_LSL: begin
                        ctrl.wr_en   = 1'b1;
                        ctrl.flag_en = 1'b1;
                    end
                    FA_LSR:  ctrl.wr_en   = 1'b1;
                    FA_INCR: ctrl.wr_en   = 1'b1;
                    FA_ZERO: ctrl.wr_en   = 1'b1;
                    FA_AND1: ctrl.flag_en = 1'b1;
                    FA_EQZ:  ctrl.flag_en = 1'b1;
                    FA_HALT: ctrl.is_halt = 1'b1;
                    default: ctrl = '0;
                endcase
            end
            OP_HAS_FUNCB: begin
                case (func)
                    FB_BNO: begin
                        ctrl.is_branch = 1'b1;
                        ctrl.br_on     = 1'b0;
                    end
                    FB_BOF: begin
                        ctrl.is_branch = 1'b1;
                        ctrl.br_on     = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM that steps the 8-bit ALU through FETCH/DECODE/EXEC/WB.
// Optional macro SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter on bus.cycle_count.
// The ALU result goes straight to the register file. Only control passes through here.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);

    seq_state_e         state;
    seq_state_e         state_next;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    instr_t             ir_f;
    logic               flag_q;
    op_ctrl_t           ctrl;
    logic               start_accept;

    logic               busy_c;
    logic               done_c;
    logic [5:0]         alu_opcode_c;
    logic [2:0]         rf_raddr_c;
    logic [2:0]         rf_waddr_c;
    logic               rf_we_c;

    assign ir_f = ir;

    // start is honoured only while parked. It is ignored during a run.
    assign start_accept = bus.start && (state == S_IDLE || state == S_HALTED);

    op_decode u_op_decode (
        .opcode (opcode_of(ir_f)),
        .ctrl   (ctrl)
    );

    // State register. Reset returns to IDLE, which drops any pending write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        state_next   = state;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        alu_opcode_c = '0;
        rf_raddr_c   = '0;
        rf_waddr_c   = '0;
        rf_we_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_FETCH;
            end
            S_FETCH: begin
                busy_c     = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                busy_c     = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy_c       = 1'b1;
                alu_opcode_c = opcode_of(ir_f);
                rf_raddr_c   = ir_f.r;
                state_next   = ctrl.is_halt ? S_HALTED : S_WB;
            end
            S_WB: begin
                busy_c     = 1'b1;
                rf_waddr_c = ir_f.r;
                rf_we_c    = ctrl.wr_en;
                state_next = S_FETCH;
            end
            S_HALTED: begin
                done_c = 1'b1;
                if (bus.start) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Program counter, instruction register and condition flag.
    // A branch tests the flag committed by the previous WB, before this WB updates it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            ir     <= '0;
            flag_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start_accept) begin
                        pc     <= bus.start_pc;
                        flag_q <= 1'b0;
                    end
                end
                S_DECODE: ir <= bus.imem_data;
                S_WB: begin
                    if (ctrl.flag_en) flag_q <= bus.alu_overflow;
                    if (ctrl.is_branch && (flag_q == ctrl.br_on)) begin
                        pc <= bus.br_target;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: pc <= pc;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.imem_addr  = pc;
    assign bus.alu_opcode = alu_opcode_c;
    assign bus.rf_raddr   = rf_raddr_c;
    assign bus.rf_waddr   = rf_waddr_c;
    assign bus.rf_we      = rf_we_c;
    assign bus.br_idx     = ir_f.r;
    assign bus.flag       = flag_q;

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count;

    // Count busy cycles of the current run. Clear on accepted start, saturate at 0xFFFF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (start_accept) begin
            cycle_count <= '0;
        end else if (busy_c && (cycle_count != 16'hFFFF)) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end

    assign bus.cycle_count = cycle_count;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a synchronous ROM model and a branch LUT.
module tb_alu_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [8:0] rom    [0:255];
    logic [7:0] br_lut [0:7];

    alu_sequencer_if #(.PC_W(8), .INSTR_W(9)) bus ();

    alu_sequencer #(.PC_W(8), .INSTR_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Synchronous ROM: data is valid the cycle after the address.
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    assign bus.br_target = br_lut[bus.br_idx];

    task tick;
        @(posedge clk);
        #1;
    endtask

    task apply_reset;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.start_pc     = 8'h00;
        bus.alu_overflow = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // Pulse start for one edge. On return the DUT is in FETCH.
    task do_start(input logic [7:0] addr);
        bus.start_pc = addr;
        bus.start    = 1'b1;
        tick;
        bus.start    = 1'b0;
    endtask

    task test_reset;
        apply_reset;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        n_cmp++; if ({bus.alu_opcode, bus.imem_addr, bus.rf_raddr, bus.rf_waddr, bus.flag} !== 21'h0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: got op=%h addr=%h ra=%h wa=%h flag=%b want all zero",
                               bus.alu_opcode, bus.imem_addr, bus.rf_raddr, bus.rf_waddr, bus.flag);
        end
`ifdef SEQ_CYCLE_COUNT_EN
        n_cmp++; if (bus.cycle_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cycle_count: got %0d want 0", bus.cycle_count); end
`endif
    endtask

    task test_add;
        apply_reset;
        rom[8'h10] = 9'b010_000_011;
        bus.alu_overflow = 1'b1;
        do_start(8'h10);
        n_cmp++; if (bus.imem_addr !== 8'h10) begin n_fail++; $display("[TB] FAIL add_fetch_addr: got %h want 10", bus.imem_addr); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL add_busy: got %b want 1", bus.busy); end
        tick;
        tick;
        n_cmp++; if (bus.alu_opcode !== 6'b010000) begin n_fail++; $display("[TB] FAIL add_exec_opcode: got %b want 010000", bus.alu_opcode); end
        n_cmp++; if (bus.rf_raddr !== 3'd3) begin n_fail++; $display("[TB] FAIL add_exec_raddr: got %0d want 3", bus.rf_raddr); end
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL add_exec_we: got %b want 0", bus.rf_we); end
        tick;
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("[TB] FAIL add_wb_we: got %b want 1", bus.rf_we); end
        n_cmp++; if (bus.rf_waddr !== 3'd3) begin n_fail++; $display("[TB] FAIL add_wb_waddr: got %0d want 3", bus.rf_waddr); end
        n_cmp++; if (bus.alu_opcode !== 6'b000000) begin n_fail++; $display("[TB] FAIL add_wb_opcode: got %b want 000000", bus.alu_opcode); end
        tick;
        n_cmp++; if (bus.flag !== 1'b1) begin n_fail++; $display("[TB] FAIL add_flag: got %b want 1", bus.flag); end
        n_cmp++; if (bus.imem_addr !== 8'h11) begin n_fail++; $display("[TB] FAIL add_next_addr: got %h want 11", bus.imem_addr); end
    endtask

    task test_branch;
        // BOF taken: ADD at 0x1F sets flag=1, BOF r2 at 0x20 jumps to LUT[2]=0x05.
        apply_reset;
        br_lut[2]  = 8'h05;
        rom[8'h1F] = 9'b010_000_000;
        rom[8'h20] = 9'b111_001_010;
        bus.alu_overflow = 1'b1;
        do_start(8'h1F);
        repeat (4) tick;
        n_cmp++; if (bus.imem_addr !== 8'h20) begin n_fail++; $display("[TB] FAIL bof_fetch_addr: got %h want 20", bus.imem_addr); end
        bus.alu_overflow = 1'b0;
        tick;
        tick;
        n_cmp++; if (bus.alu_opcode !== 6'b111001) begin n_fail++; $display("[TB] FAIL bof_exec_opcode: got %b want 111001", bus.alu_opcode); end
        tick;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL bof_taken_we: got %b want 0", bus.rf_we); end
        tick;
        n_cmp++; if (bus.imem_addr !== 8'h05) begin n_fail++; $display("[TB] FAIL bof_taken_pc: got %h want 05", bus.imem_addr); end
        n_cmp++; if (bus.flag !== 1'b1) begin n_fail++; $display("[TB] FAIL bof_flag_kept: got %b want 1", bus.flag); end
        // BOF not taken: start clears the flag.
        apply_reset;
        do_start(8'h20);
        repeat (3) tick;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL bof_nt_we: got %b want 0", bus.rf_we); end
        tick;
        n_cmp++; if (bus.imem_addr !== 8'h21) begin n_fail++; $display("[TB] FAIL bof_nt_pc: got %h want 21", bus.imem_addr); end
        // BNO taken with flag=0: BNO r4 at 0x30 jumps to LUT[4]=0x40.
        apply_reset;
        br_lut[4]  = 8'h40;
        rom[8'h30] = 9'b111_000_100;
        do_start(8'h30);
        repeat (4) tick;
        n_cmp++; if (bus.imem_addr !== 8'h40) begin n_fail++; $display("[TB] FAIL bno_taken_pc: got %h want 40", bus.imem_addr); end
    endtask

    task test_wrap;
        apply_reset;
        rom[8'hFF] = 9'b110_010_001;
        do_start(8'hFF);
        repeat (3) tick;
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("[TB] FAIL incr_we: got %b want 1", bus.rf_we); end
        n_cmp++; if (bus.rf_waddr !== 3'd1) begin n_fail++; $display("[TB] FAIL incr_waddr: got %0d want 1", bus.rf_waddr); end
        tick;
        n_cmp++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h want 00", bus.imem_addr); end
    endtask

    task test_halt;
        apply_reset;
        rom[8'h03] = 9'b110_111_000;
        bus.start_pc = 8'h03;
        bus.start    = 1'b1;
        tick;
        bus.start_pc = 8'h60;
        tick;
        tick;
        n_cmp++; if (bus.alu_opcode !== 6'b110111) begin n_fail++; $display("[TB] FAIL halt_exec_opcode: got %b want 110111", bus.alu_opcode); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_exec_done: got %b want 0", bus.done); end
        bus.start = 1'b0;
        tick;
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_busy: got %b want 0", bus.busy); end
        tick;
        tick;
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_hold: got %b want 1", bus.done); end
        do_start(8'h03);
        n_cmp++; if ({bus.done, bus.busy} !== 2'b01) begin n_fail++; $display("[TB] FAIL restart_flags: got done/busy=%b want 01", {bus.done, bus.busy}); end
        n_cmp++; if (bus.imem_addr !== 8'h03) begin n_fail++; $display("[TB] FAIL restart_addr: got %h want 03", bus.imem_addr); end
    endtask

    task test_program;
        // ADD, LSL, HALT from 0x00 with start held high (and a bogus start_pc) during the ADD.
        apply_reset;
        rom[8'h00] = 9'b010_000_001;
        rom[8'h01] = 9'b110_000_010;
        rom[8'h02] = 9'b110_111_000;
        do_start(8'h00);
        bus.start_pc = 8'h60;
        bus.start    = 1'b1;
        repeat (4) tick;
        bus.start = 1'b0;
        n_cmp++; if (bus.imem_addr !== 8'h01) begin n_fail++; $display("[TB] FAIL prog_lsl_addr: got %h want 01", bus.imem_addr); end
`ifdef SEQ_CYCLE_COUNT_EN
        n_cmp++; if (bus.cycle_count !== 16'd4) begin n_fail++; $display("[TB] FAIL prog_count_mid: got %0d want 4", bus.cycle_count); end
`endif
        repeat (4) tick;
        n_cmp++; if (bus.imem_addr !== 8'h02) begin n_fail++; $display("[TB] FAIL prog_halt_addr: got %h want 02", bus.imem_addr); end
        repeat (3) tick;
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL prog_done: got %b want 1", bus.done); end
`ifdef SEQ_CYCLE_COUNT_EN
        n_cmp++; if (bus.cycle_count !== 16'd11) begin n_fail++; $display("[TB] FAIL prog_count: got %0d want 11", bus.cycle_count); end
        repeat (3) tick;
        n_cmp++; if (bus.cycle_count !== 16'd11) begin n_fail++; $display("[TB] FAIL prog_count_hold: got %0d want 11", bus.cycle_count); end
`endif
    endtask

    task test_undefined;
        // ADD sets flag=1, then undefined 000/101 and A-type func 110 must change nothing but pc.
        apply_reset;
        rom[8'h08] = 9'b010_000_000;
        rom[8'h09] = 9'b000_101_010;
        rom[8'h0A] = 9'b110_110_011;
        bus.alu_overflow = 1'b1;
        do_start(8'h08);
        repeat (4) tick;
        n_cmp++; if (bus.flag !== 1'b1) begin n_fail++; $display("[TB] FAIL undef_setup_flag: got %b want 1", bus.flag); end
        bus.alu_overflow = 1'b0;
        repeat (3) tick;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL undef_we: got %b want 0", bus.rf_we); end
        tick;
        n_cmp++; if (bus.flag !== 1'b1) begin n_fail++; $display("[TB] FAIL undef_flag: got %b want 1", bus.flag); end
        n_cmp++; if (bus.imem_addr !== 8'h0A) begin n_fail++; $display("[TB] FAIL undef_pc: got %h want 0a", bus.imem_addr); end
        repeat (3) tick;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL undef_a_we: got %b want 0", bus.rf_we); end
        tick;
        n_cmp++; if ({bus.flag, bus.imem_addr} !== 9'h10B) begin n_fail++; $display("[TB] FAIL undef_a_state: got flag=%b pc=%h want flag=1 pc=0b", bus.flag, bus.imem_addr); end
    endtask

    task test_reset_mid;
        apply_reset;
        rom[8'h10] = 9'b010_000_011;
        bus.alu_overflow = 1'b1;
        do_start(8'h10);
        repeat (3) tick;
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_wb_we: got %b want 1", bus.rf_we); end
        rst_n = 1'b0;
        tick;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_we: got %b want 0", bus.rf_we); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL rmid_pc: got %h want 00", bus.imem_addr); end
        n_cmp++; if (bus.flag !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_flag: got %b want 0", bus.flag); end
        rst_n = 1'b1;
        tick;
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("[TB] FAIL rmid_idle: got busy/done=%b want 00", {bus.busy, bus.done}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
        for (int i = 0; i < 8; i++) br_lut[i] = 8'h00;
        $display("[TB] alu_sequencer directed test start");
        test_reset;
        test_add;
        test_branch;
        test_wrap;
        test_halt;
        test_program;
        test_undefined;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences the 8-bit ALU for the CSE141L core. Fetches 9-bit instructions from the synchronous instruction ROM, drives the ALU's 6-bit opcode and register-file addresses, and owns the overflow/condition flag. Resolves BNO/BOF branches and HALT. Sits between the instruction ROM, register file and ALU; the ALU result bus goes directly to the register-file write port and never passes through this block.

## Interface
Parameters:
- PC_W, 8, program-counter and ROM address width
- INSTR_W, 9, instruction width; fixed encoding below, not to be changed

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  begin execution at start_pc; sampled only in IDLE or HALTED
- start_pc  in  PC_W  first instruction address
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- done  out  1  high while in HALTED
- imem_addr  out  PC_W  ROM address; ROM data valid one cycle later
- imem_data  in  INSTR_W  [8:3]=ALU opcode (op[5:3], func[2:0]); [2:0]=reg field r
- alu_opcode  out  6  opcode presented to the ALU
- alu_overflow  in  1  ALU overflow output
- rf_raddr  out  3  IN2 source register (IN1 is fixed to R0)
- rf_waddr  out  3  write-back register
- rf_we  out  1  one-cycle write strobe
- br_idx  out  3  branch-target LUT index (= r)
- br_target  in  PC_W  combinational LUT output
- flag  out  1  condition flag
- cycle_count  out  16  present only with SEQ_CYCLE_COUNT_EN

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE/HALTED with start=1: pc<=start_pc, flag<=0, go to FETCH.
- FETCH: imem_addr=pc. Next state is DECODE.
- DECODE: ir<=imem_data. Next state is EXEC.
- EXEC: alu_opcode=ir[8:3]; rf_raddr=ir[2:0]. The ALU registers the op at the end of this cycle. Next state is WB, or HALTED if the op is HALT (110/111).
- WB: rf_waddr=ir[2:0]. Writes, flag updates and pc updates are per op:
  - Result ops ADD(010), DIST(101), and A-type LSL/LSR/INCR/ZERO: rf_we=1.
  - Flag ops ADD, MATCH(011), LT(100), LSL, AND1, EQZ: flag<=alu_overflow.
  - BNO (111/000): pc<=br_target if flag==0, else pc+1.
  - BOF (111/001): pc<=br_target if flag==1, else pc+1.
  - All other ops: pc<=pc+1.
- Undefined encodings (op 000/001, A-type func 110, B-type func 010–111) execute as NOP: no write, no flag change, pc+1.
- pc arithmetic is modulo 2^PC_W: 0xFF+1 wraps to 0x00, with no error.

## Timing
- Reset values: state=IDLE, pc=0, ir=0, flag=0, busy=0, done=0, rf_we=0, alu_opcode=0, rf_raddr=0, rf_waddr=0, imem_addr=0, cycle_count=0.
- Reset is synchronous and has priority over everything. When asserted mid-instruction, the next edge returns the block to IDLE and the pending rf_we is dropped.
- Every instruction takes 4 cycles from FETCH to WB, including taken branches. HALT takes 3 cycles (FETCH, DECODE, EXEC) and then enters HALTED.
- start asserted while busy is ignored.
- HALTED holds done=1 until the next start. When start arrives, done drops on the same edge that FETCH is entered.
- alu_opcode is driven only in EXEC and is 0 otherwise. rf_we is high only in WB.
- A branch reads the flag value committed by the previous WB. Branch-to-self is legal and loops.

## Configuration
- SEQ_CYCLE_COUNT_EN defined:
  - cycle_count clears on an accepted start and increments in every busy cycle.
  - It saturates at 0xFFFF and holds its value in HALTED.
- Not defined: the port and the counter do not exist.

## Structure
- Package alu_pkg holds the shared encodings: op constants (ADD, MATCH, LT, DIST, HAS_FUNCA, HAS_FUNCB), A-func and B-func constants, the sequencer state enum, and an instruction field typedef.
- The ALU and this block both import alu_pkg.
- Sub-module op_decode: combinational; maps ir to {wr_en, flag_en, is_branch, br_on, is_halt}.

## Test plan
- Reset mid-run: assert rst_n=0 during WB of an ADD → next cycle rf_we=0, state IDLE, pc=0, flag=0.
- start_pc=0x10, ROM[0x10]=ADD r3, ALU overflow=1 → WB on cycle 4 with rf_we=1, rf_waddr=3, flag=1, next imem_addr=0x11.
- flag=1, BOF r2 at 0x20, br_target=0x05 → pc=0x05. The same instruction with flag=0 → pc=0x21. Neither case asserts rf_we.
- pc=0xFF executing INCR → next fetch at imem_addr=0x00.
- HALT at 0x03 → done=1 after 3 cycles; start held during the run is ignored. With SEQ_CYCLE_COUNT_EN and program ADD, LSL, HALT from 0x00, cycle_count=11.
- Undefined opcode 000/101 → no rf_we, flag unchanged, pc+1.
